logic_gate_pipe: RTL and testbench

//  - Parametrised, pipelined N-input bitwise logic unit: reduces NUM_IN operand channels of WIDTH bits with a
//    per-transfer selectable op (AND/OR/XOR/NAND/NOR/XNOR). Result is registered through DEPTH stages.
//  - Successor to the 2-input combinational gate primitives in basic_gates/. Adds channel count, op select,

---
 rtl/logic_gate_pkg.sv | 35 +++
 rtl/logic_gate_stage.sv | 35 +++
 rtl/logic_gate_pipe.sv | 100 ++++++++++
 tb/tb_logic_gate_pipe.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared op-code encoding and identity helpers for the pipelined logic unit.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    // Codes 6 and 7 are deliberately unnamed: they are the illegal encodings.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    // Identity bit of the base (non-inverted) reduction: ones for AND, zero for OR/XOR.
    function automatic logic op_identity(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_NAND: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic op_inverted(input logic [OP_W-1:0] op);
        case (op)
            OP_NAND, OP_NOR, OP_XNOR: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One {valid,data,err} register slice with load/hold/clear and ready-out logic.
module logic_gate_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    input  logic             out_ready
);

    // The slice can take new content when empty or when its content leaves this cycle.
    assign in_ready = rst_n && (!out_valid || out_ready);

    // Load on ready (bubbles clear valid but leave data untouched), otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_err  <= in_err;
            end
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined NUM_IN-channel bitwise logic unit with masking and valid/ready flow control.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [OP_W-1:0]         IN_OP,
    input  logic [NUM_IN-1:0]       IN_MASK,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic                    OUT_ERR
);

    logic [WIDTH-1:0] ident;
    logic [WIDTH-1:0] chan;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic             err;

    // Masked reduction: disabled channels contribute the identity, N-ops invert the base result.
    always_comb begin
        ident  = {WIDTH{op_identity(IN_OP)}};
        acc    = ident;
        chan   = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            chan = IN_MASK[k] ? IN_DATA[k*WIDTH +: WIDTH] : ident;
            case (IN_OP)
                OP_AND, OP_NAND: acc = acc & chan;
                OP_OR,  OP_NOR:  acc = acc | chan;
                default:         acc = acc ^ chan;
            endcase
        end
        err    = 1'b0;
        result = acc;
        if (!op_legal(IN_OP)) begin
            result = '0;
            err    = 1'b1;
        end else if (op_inverted(IN_OP)) begin
            result = ~acc;
        end
    end

    // Each slice lives in its own scope so the ready chain runs through distinct
    // signals; the last slice takes OUT_READY, the others the next slice's ready.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_in;
        logic             e_in;
        logic             rdy_in;
        logic             rdy_out;
        logic             v_out;
        logic             e_out;
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;

        if (i == 0) begin : g_head
            assign v_in = IN_VALID;
            assign d_in = result;
            assign e_in = err;
        end else begin : g_link
            assign v_in = g_stage[i-1].v_out;
            assign d_in = g_stage[i-1].d_out;
            assign e_in = g_stage[i-1].e_out;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign rdy_out = OUT_READY;
        end else begin : g_mid
            assign rdy_out = g_stage[i+1].rdy_in;
        end

        logic_gate_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (RSTn),
            .in_valid (v_in),
            .in_data  (d_in),
            .in_err   (e_in),
            .in_ready (rdy_in),
            .out_valid(v_out),
            .out_data (d_out),
            .out_err  (e_out),
            .out_ready(rdy_out)
        );
    end

    assign IN_READY  = g_stage[0].rdy_in;
    assign OUT_VALID = g_stage[DEPTH-1].v_out;
    assign OUT_DATA  = g_stage[DEPTH-1].d_out;
    assign OUT_ERR   = g_stage[DEPTH-1].e_out;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=4, NUM_IN=3, DEPTH=2).
module tb_logic_gate_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_mask;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    logic_gate_pipe #(
        .WIDTH (4),
        .NUM_IN(3),
        .DEPTH (2)
    ) dut (
        .CLK      (clk),
        .RSTn     (rst_n),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .IN_OP    (in_op),
        .IN_MASK  (in_mask),
        .IN_DATA  (in_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .OUT_DATA (out_data),
        .OUT_ERR  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transfer with OUT_READY=1: accepted at the next edge,
    // absent after one edge, present with the expected result after two.
    task automatic xfer(input string tag, input logic [2:0] op, input logic [2:0] mask,
                        input logic [11:0] data, input logic [3:0] exp_d, input logic exp_e);
        in_op    = op;
        in_mask  = mask;
        in_data  = data;
        in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(out_err), 32'(exp_e));
        step();
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_mask   = 3'b111;
        in_data   = 12'h000;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        // AND of {F,A,6}: 1010 & 0110 & 1111 = 0010
        xfer("and111", 3'd0, 3'b111, 12'hFA6, 4'h2, 1'b0);

        // Back-to-back XOR (F^A^6=3) then XNOR (C)
        in_op = 3'd2; in_mask = 3'b111; in_data = 12'hFA6; in_valid = 1'b1;
        step();
        in_op = 3'd5;
        chk("b2b_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_v0", 32'(out_valid), 32'd1);
        chk("b2b_xor", 32'(out_data), 32'h3);
        step();
        chk("b2b_v1", 32'(out_valid), 32'd1);
        chk("b2b_xnor", 32'(out_data), 32'hC);
        step();
        chk("b2b_end", 32'(out_valid), 32'd0);

        // Masking and identity elements
        xfer("and001", 3'd0, 3'b001, 12'hFA6, 4'h6, 1'b0);
        xfer("or000", 3'd1, 3'b000, 12'hFA6, 4'h0, 1'b0);
        xfer("nand000", 3'd3, 3'b000, 12'hFA6, 4'h0, 1'b0);
        xfer("nor000", 3'd4, 3'b000, 12'hFA6, 4'hF, 1'b0);
        xfer("xor110", 3'd2, 3'b110, 12'hFA6, 4'h5, 1'b0);

        // Backpressure: A=OR 111 -> F, B=AND 011 -> A&6=2, C=XOR 110 -> F^A=5
        out_ready = 1'b0;
        in_op = 3'd1; in_mask = 3'b111; in_data = 12'hFA6; in_valid = 1'b1;
        chk("bp_rdyA", 32'(in_ready), 32'd1);
        step();
        in_op = 3'd0; in_mask = 3'b011;
        chk("bp_rdyB", 32'(in_ready), 32'd1);
        step();
        in_op = 3'd2; in_mask = 3'b110;
        chk("bp_rdyC", 32'(in_ready), 32'd0);
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_dataA", 32'(out_data), 32'hF);
        step();
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'hF);
        step();
        chk("bp_hold_data2", 32'(out_data), 32'hF);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_vB", 32'(out_valid), 32'd1);
        chk("bp_dataB", 32'(out_data), 32'h2);
        step();
        chk("bp_vC", 32'(out_valid), 32'd1);
        chk("bp_dataC", 32'(out_data), 32'h5);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Illegal op, then a legal op clears the error flag
        xfer("illegal6", 3'd6, 3'b111, 12'hFFF, 4'h0, 1'b1);
        xfer("illegal7", 3'd7, 3'b101, 12'hFA6, 4'h0, 1'b1);
        xfer("legal_after", 3'd0, 3'b111, 12'hFFF, 4'hF, 1'b0);

        // Reset with two results in flight
        out_ready = 1'b0;
        in_op = 3'd0; in_mask = 3'b111; in_data = 12'hFFF; in_valid = 1'b1;
        step();
        in_op = 3'd6;
        step();
        in_valid = 1'b0;
        chk("fl_vld", 32'(out_valid), 32'd1);
        chk("fl_data", 32'(out_data), 32'hF);
        rst_n = 1'b0;
        step();
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_err", 32'(out_err), 32'd0);
        chk("mr_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr_rel_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_ghost", 32'(out_valid), 32'd0);
        end

        xfer("post_rst", 3'd1, 3'b011, 12'h0A6, 4'hE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
